pix_stream_out: RTL

//  Downstream readout stage for the vector data memory's pixel array (8-bit pixels, linear index).
//  On a start pulse it walks the whole image in raster order through a synchronous 1-cycle-latency read port.
//  It emits one pixel per beat on a valid/ready stream with row and frame markers.

---
 rtl/pix_stream_out.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pix_stream_out.sv
`default_nettype none
// ============================================================================
//  Module   : pix_stream_out
//  Purpose  : Raster-order readout of the pixel array through a 1-cycle
//             synchronous read port. Pixels leave on a valid/ready stream
//             with end-of-row and end-of-frame markers. A 2-entry output
//             buffer hides the read latency, so the stream can run at one
//             pixel per cycle under backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module pix_stream_out #(
  parameter int IMAGE_WIDTH  = 120,
  parameter int IMAGE_HEIGHT = 120,
  parameter int PIX_SIZE     = 8,
  parameter int BASE_ADDR    = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_ren,
  output logic [15:0]         mem_addr,
  input  logic [PIX_SIZE-1:0] mem_rd,
  output logic [PIX_SIZE-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_eol,
  output logic                pix_last
);

  localparam int c_num_pix = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int c_col_w   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int c_row_w   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMAGE_WIDTH - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMAGE_HEIGHT - 1);
  localparam logic [15:0]        c_last_idx = 16'(c_num_pix - 1);
  localparam logic [15:0]        c_base     = 16'(BASE_ADDR);

  // Geometry must be non-empty and the whole frame must sit in the 16-bit index space.
  generate
    if (IMAGE_WIDTH < 1 || IMAGE_HEIGHT < 1 || PIX_SIZE < 1 || BASE_ADDR < 0 ||
        (BASE_ADDR + c_num_pix - 1) > 65535) begin : g_bad_params
      $error("pix_stream_out: illegal image geometry or base address");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          idx_q, idx_d;           // index of the next read to issue
  logic [c_col_w-1:0]   col_q, col_d;           // column tag of the next read
  logic [c_row_w-1:0]   row_q, row_d;           // row tag of the next read
  logic                 inflight_q, inflight_d; // a read was issued last cycle
  logic                 infl_eol_q, infl_eol_d;
  logic                 infl_last_q, infl_last_d;

  logic [1:0]           cnt_q, cnt_d;           // buffer occupancy 0..2
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [PIX_SIZE-1:0]  buf_data_q [2];
  logic [PIX_SIZE-1:0]  buf_data_d [2];
  logic [1:0]           buf_eol_q, buf_eol_d;
  logic [1:0]           buf_last_q, buf_last_d;

  logic                 push;
  logic                 pop;
  logic [2:0]           occ_after;              // occupancy the buffer would reach counting the read in flight

  assign pix_valid = (cnt_q != 2'd0);
  assign pix_data  = buf_data_q[rd_ptr_q];
  assign pix_eol   = pix_valid & buf_eol_q[rd_ptr_q];
  assign pix_last  = pix_valid & buf_last_q[rd_ptr_q];
  assign mem_addr  = c_base + idx_q;

  assign push      = inflight_q;
  assign pop       = pix_valid & pix_ready;
  assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Frame state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Frame sequencing: read issue, raster tags and handshake-driven completion.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    row_d       = row_q;
    inflight_d  = 1'b0;
    infl_eol_d  = infl_eol_q;
    infl_last_d = infl_last_q;
    mem_ren     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          idx_d   = 16'd0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        // Only issue when the buffer is guaranteed a free slot for the returning data.
        if (occ_after < 3'd2) begin
          mem_ren     = 1'b1;
          inflight_d  = 1'b1;
          infl_eol_d  = (col_q == c_last_col);
          infl_last_d = (col_q == c_last_col) && (row_q == c_last_row);
          if (col_q == c_last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (idx_q == c_last_idx) state_d = ST_FLUSH;
          else                     idx_d   = idx_q + 16'd1;
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        // Leave as soon as the final pop empties the buffer, so done follows the last beat directly.
        if (!inflight_q && cnt_d == 2'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        idx_d   = 16'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output buffer: read data lands in the tail slot, the head slot drives the stream.
  always_comb begin
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    buf_data_d = buf_data_q;
    buf_eol_d  = buf_eol_q;
    buf_last_d = buf_last_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = mem_rd;
      buf_eol_d[wr_ptr_q]  = infl_eol_q;
      buf_last_d[wr_ptr_q] = infl_last_q;
    end
  end

  // Datapath registers; reset aborts any read in flight and empties the buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q       <= 16'd0;
      col_q       <= '0;
      row_q       <= '0;
      inflight_q  <= 1'b0;
      infl_eol_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_eol_q   <= 2'b00;
      buf_last_q  <= 2'b00;
    end else begin
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      inflight_q  <= inflight_d;
      infl_eol_q  <= infl_eol_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_data_q  <= buf_data_d;
      buf_eol_q   <= buf_eol_d;
      buf_last_q  <= buf_last_d;
    end
  end

endmodule
`default_nettype wire
